// File: rtl/button_event.sv
// Turns a debounced switch level into PRESS / RELEASE / LONG / REPEAT events.
// Events are offered through a single-entry valid/ready buffer; the FSM never stalls.
module button_event #(
  parameter bit ACTIVE_LEVEL          = 1'b1,
  parameter int LONG_PRESS_TICKS      = 1000,
  parameter int REPEAT_INTERVAL_TICKS = 100,
  parameter bit ENABLE_REPEAT         = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       switch_in,
  output logic       pressed,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [1:0] event_code,
  output logic       overflow
);

  localparam int CNT_MAX = (LONG_PRESS_TICKS > REPEAT_INTERVAL_TICKS) ?
                           LONG_PRESS_TICKS : REPEAT_INTERVAL_TICKS;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_INTERVAL_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             prev_act_reg;
  logic             pressed_reg;
  logic             valid_reg;
  logic [1:0]       code_reg;
  logic             overflow_reg;

  logic             act;
  logic             rise;
  logic             fall;
  logic             gen_valid;
  logic [1:0]       gen_code;

  // Edge detection runs every clock; only the hold counter is tick-gated.
  assign act  = (switch_in == ACTIVE_LEVEL);
  assign rise = act && !prev_act_reg;
  assign fall = !act && prev_act_reg;

  // State register, counter and event buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= CNT_ZERO;
      prev_act_reg <= 1'b0;
      pressed_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      code_reg     <= EV_PRESS;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      prev_act_reg <= act;
      pressed_reg  <= (state_next != ST_IDLE);
      overflow_reg <= 1'b0;
      if (!valid_reg || event_ready) begin
        valid_reg <= gen_valid;
        if (gen_valid) begin
          code_reg <= gen_code;
        end
      end else if (gen_valid) begin
        // Consumer is stalling: keep the held event, flag the lost one.
        overflow_reg <= 1'b1;
      end
    end
  end

  // Next-state and hold-counter logic; fall always wins over a same-cycle tick.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_PRESSED;
          count_next = CNT_ZERO;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_next = ST_IDLE;
          count_next = CNT_ZERO;
        end else if (tick) begin
          if (count_reg == LONG_LAST) begin
            state_next = ST_LONG_HELD;
            count_next = CNT_ZERO;
          end else begin
            count_next = count_reg + CNT_ONE;
          end
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_next = ST_IDLE;
          count_next = CNT_ZERO;
        end else if (!ENABLE_REPEAT) begin
          count_next = CNT_ZERO;
        end else if (tick) begin
          if (count_reg == REPEAT_LAST) begin
            count_next = CNT_ZERO;
          end else begin
            count_next = count_reg + CNT_ONE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = CNT_ZERO;
      end
    endcase
  end

  // Event generation: at most one event per cycle.
  always_comb begin
    gen_valid = 1'b0;
    gen_code  = EV_PRESS;
    case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          gen_valid = 1'b1;
          gen_code  = EV_PRESS;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          gen_valid = 1'b1;
          gen_code  = EV_RELEASE;
        end else if (tick && (count_reg == LONG_LAST)) begin
          gen_valid = 1'b1;
          gen_code  = EV_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          gen_valid = 1'b1;
          gen_code  = EV_RELEASE;
        end else if (ENABLE_REPEAT && tick && (count_reg == REPEAT_LAST)) begin
          gen_valid = 1'b1;
          gen_code  = EV_REPEAT;
        end
      end
      default: begin
        gen_valid = 1'b0;
        gen_code  = EV_PRESS;
      end
    endcase
  end

  assign pressed     = pressed_reg;
  assign event_valid = valid_reg;
  assign event_code  = code_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: per-cycle vector table plus hand-written sequences.
module tb_button_event;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       switch_in;
  logic       event_ready;

  logic       a_pressed, a_valid, a_overflow;
  logic [1:0] a_code;
  logic       b_pressed, b_valid, b_overflow;
  logic [1:0] b_code;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  button_event #(
    .ACTIVE_LEVEL(1'b1), .LONG_PRESS_TICKS(4), .REPEAT_INTERVAL_TICKS(2), .ENABLE_REPEAT(1'b1)
  ) dut_a (
    .clock(clock), .reset(reset), .tick(tick), .switch_in(switch_in),
    .pressed(a_pressed), .event_valid(a_valid), .event_ready(event_ready),
    .event_code(a_code), .overflow(a_overflow)
  );

  button_event #(
    .ACTIVE_LEVEL(1'b1), .LONG_PRESS_TICKS(4), .REPEAT_INTERVAL_TICKS(2), .ENABLE_REPEAT(1'b0)
  ) dut_b (
    .clock(clock), .reset(reset), .tick(tick), .switch_in(switch_in),
    .pressed(b_pressed), .event_valid(b_valid), .event_ready(event_ready),
    .event_code(b_code), .overflow(b_overflow)
  );

  typedef struct {
    int         id;
    logic       rst;
    logic       sw;
    logic       tk;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_code;
    logic       e_pressed;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int id, input logic rst, input logic sw, input logic tk,
                              input logic rdy, input logic ev, input logic [1:0] ec,
                              input logic ep, input logic eo);
    vec_t v;
    v.id = id; v.rst = rst; v.sw = sw; v.tk = tk; v.rdy = rdy;
    v.e_valid = ev; v.e_code = ec; v.e_pressed = ep; v.e_ovf = eo;
    return v;
  endfunction

  // Drive inputs just after an edge, advance one clock, sample 1 ns later.
  task automatic step(input logic rst, input logic sw, input logic tk, input logic rdy);
    reset = rst; switch_in = sw; tick = tk; event_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic chk_code,
                       input logic av, input logic [1:0] ac, input logic ap, input logic ao,
                       input logic ev, input logic [1:0] ec, input logic ep, input logic eo);
    tests_run++;
    if ((av !== ev) || (chk_code && (ac !== ec)) || (ap !== ep) || (ao !== eo)) begin
      tests_failed++;
      $display("FAIL %s: got valid=%0b code=%0d pressed=%0b ovf=%0b, want valid=%0b code=%0d pressed=%0b ovf=%0b",
               name, av, ac, ap, ao, ev, ec, ep, eo);
    end
  endtask

  initial begin
    logic [1:0] codes[$];

    // Test 2: LONG=4, REPEAT=2, tick every clock
    vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 1, 1, 1, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 0, 1, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(2, 0, 1, 1, 1, 1, 2, 1, 0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(2, 0, 1, 1, 1, 0, 0, 1, 0));
      vecs.push_back(mk(2, 0, 1, 1, 1, 1, 3, 1, 0));
    end
    vecs.push_back(mk(2, 0, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(2, 0, 0, 1, 1, 0, 0, 0, 0));
    // Test 3: backpressure, RELEASE dropped
    vecs.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 0));
    // Test 4: fall on the 4th tick gives RELEASE only
    vecs.push_back(mk(4, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 1, 1, 1, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4, 0, 1, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4, 0, 0, 1, 1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4, 0, 0, 1, 1, 0, 0, 0, 0));
    // Test 5: reset in LONG_HELD with pending LONG, switch held
    vecs.push_back(mk(5, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 1, 1, 1, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(5, 0, 1, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(5, 0, 1, 1, 1, 1, 2, 1, 0));
    vecs.push_back(mk(5, 0, 1, 1, 0, 1, 2, 1, 0));
    vecs.push_back(mk(5, 0, 1, 1, 0, 1, 2, 1, 1));
    vecs.push_back(mk(5, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 1, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(5, 0, 1, 0, 1, 0, 0, 1, 0));

    // Initial reset
    reset = 1'b1; switch_in = 1'b0; tick = 1'b0; event_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_a", 1'b1, a_valid, a_code, a_pressed, a_overflow, 0, 0, 0, 0);
    check("reset_b", 1'b1, b_valid, b_code, b_pressed, b_overflow, 0, 0, 0, 0);

    // Test 1: tick every 8 clocks, release after 3 ticks, no LONG
    step(0, 1, 0, 1);
    check("t1_press", 1'b1, a_valid, a_code, a_pressed, a_overflow, 1, 0, 1, 0);
    $display("[TB] t1 press: valid=%0b code=%0d", a_valid, a_code);
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) begin
        step(0, 1, (k == 7), 1);
        check("t1_hold", 1'b0, a_valid, a_code, a_pressed, a_overflow, 0, 0, 1, 0);
      end
    end
    step(0, 0, 0, 1);
    check("t1_release", 1'b1, a_valid, a_code, a_pressed, a_overflow, 1, 1, 0, 0);
    $display("[TB] t1 release: valid=%0b code=%0d", a_valid, a_code);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, (k % 8 == 7), 1);
      check("t1_idle", 1'b0, a_valid, a_code, a_pressed, a_overflow, 0, 0, 0, 0);
    end

    // Tests 2-5 from the vector table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].sw, vecs[i].tk, vecs[i].rdy);
      check($sformatf("t%0d_vec%0d", vecs[i].id, i), vecs[i].e_valid | vecs[i].rst,
            a_valid, a_code, a_pressed, a_overflow,
            vecs[i].e_valid, vecs[i].e_code, vecs[i].e_pressed, vecs[i].e_ovf);
      $display("[TB] vec %0d (t%0d): valid=%0b code=%0d pressed=%0b ovf=%0b",
               i, vecs[i].id, a_valid, a_code, a_pressed, a_overflow);
    end

    // Test 6: ENABLE_REPEAT=0, hold 30 ticks -> PRESS, LONG only
    step(1, 0, 0, 1);
    check("t6_reset", 1'b1, b_valid, b_code, b_pressed, b_overflow, 0, 0, 0, 0);
    for (int k = 0; k < 31; k++) begin
      step(0, 1, 1, 1);
      if (b_valid) codes.push_back(b_code);
    end
    tests_run++;
    if (codes.size() != 2) begin
      tests_failed++;
      $display("FAIL t6_count: got %0d events, want 2", codes.size());
    end else begin
      check("t6_first", 1'b1, 1'b1, codes[0], b_pressed, b_overflow, 1, 0, 1, 0);
      check("t6_second", 1'b1, 1'b1, codes[1], b_pressed, b_overflow, 1, 2, 1, 0);
    end
    $display("[TB] t6 held: %0d events seen", codes.size());
    step(0, 0, 1, 1);
    check("t6_release", 1'b1, b_valid, b_code, b_pressed, b_overflow, 1, 1, 0, 0);
    step(0, 0, 1, 1);
    check("t6_idle", 1'b0, b_valid, b_code, b_pressed, b_overflow, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
